// File: rtl/load_store_unit.sv
// Load/store unit: data-memory initiator. Accepts one load/store command,
// issues a word-aligned byte-enabled request on a valid/ready bus, waits for
// the response, formats load data and reports completion or a fault.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [2:0]  cmd_func3,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_write,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_be,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_rdata,
  input  logic        mem_rsp_err,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam int unsigned   CW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  localparam logic [1:0] E_MISALIGN = 2'd0;
  localparam logic [1:0] E_ILLEGAL  = 2'd1;
  localparam logic [1:0] E_BUS      = 2'd2;
  localparam logic [1:0] E_TIMEOUT  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    f3_q, f3_d;
  logic [1:0]    lane_q, lane_d;
  logic          req_valid_q, req_valid_d;
  logic          req_write_q, req_write_d;
  logic [31:0]   req_addr_q, req_addr_d;
  logic [31:0]   req_wdata_q, req_wdata_d;
  logic [3:0]    req_be_q, req_be_d;
  logic          done_q, done_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [1:0]    code_q, code_d;

  logic [1:0]  lane;
  logic        cmd_legal, cmd_misal;
  logic [3:0]  cmd_be;
  logic [31:0] cmd_wd;
  logic [31:0] rsp_sh, load_val;
  logic        at_limit;

  assign cmd_ready     = (state_q == S_IDLE) && !reset;
  assign mem_req_valid = req_valid_q;
  assign mem_req_write = req_write_q;
  assign mem_req_addr  = req_addr_q;
  assign mem_req_wdata = req_wdata_q;
  assign mem_req_be    = req_be_q;
  assign done          = done_q;
  assign rdata         = rdata_q;
  assign err           = err_q;
  assign err_code      = code_q;

  // Command decode: legality, alignment, byte enables and replicated store data
  always_comb begin
    lane      = cmd_addr[1:0];
    cmd_legal = 1'b0;
    cmd_misal = 1'b0;
    cmd_be    = '0;
    cmd_wd    = '0;
    case (cmd_func3)
      3'b000, 3'b100: begin
        cmd_legal = !(cmd_write && cmd_func3[2]);
        cmd_be    = 4'b0001 << lane;
        cmd_wd    = {4{cmd_wdata[7:0]}};
      end
      3'b001, 3'b101: begin
        cmd_legal = !(cmd_write && cmd_func3[2]);
        cmd_misal = lane[0];
        cmd_be    = 4'b0011 << lane;
        cmd_wd    = {2{cmd_wdata[15:0]}};
      end
      3'b010: begin
        cmd_legal = 1'b1;
        cmd_misal = (lane != 2'b00);
        cmd_be    = 4'b1111;
        cmd_wd    = cmd_wdata;
      end
      default: ;
    endcase
    if (!cmd_write) cmd_wd = '0;
  end

  // Load lane extraction and sign/zero extension
  always_comb begin
    rsp_sh = mem_rsp_rdata >> {lane_q, 3'b000};
    case (f3_q)
      3'b000:  load_val = {{24{rsp_sh[7]}}, rsp_sh[7:0]};
      3'b100:  load_val = {24'd0, rsp_sh[7:0]};
      3'b001:  load_val = {{16{rsp_sh[15]}}, rsp_sh[15:0]};
      3'b101:  load_val = {16'd0, rsp_sh[15:0]};
      default: load_val = mem_rsp_rdata;
    endcase
  end

  assign at_limit = (cnt_q >= CNT_LAST);

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    f3_d        = f3_q;
    lane_d      = lane_q;
    req_valid_d = req_valid_q;
    req_write_d = req_write_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_be_d    = req_be_q;
    done_d      = 1'b0;
    rdata_d     = rdata_q;
    err_d       = err_q;
    code_d      = code_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          f3_d   = cmd_func3;
          lane_d = lane;
          if (!cmd_legal || cmd_misal) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
            code_d  = cmd_legal ? E_MISALIGN : E_ILLEGAL;
            rdata_d = '0;
          end else begin
            state_d     = S_REQ;
            cnt_d       = '0;
            req_valid_d = 1'b1;
            req_write_d = cmd_write;
            req_addr_d  = {cmd_addr[31:2], 2'b00};
            req_wdata_d = cmd_wd;
            req_be_d    = cmd_be;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + CW'(1);
        if (mem_req_ready) begin
          state_d     = S_WAIT;
          req_valid_d = 1'b0;
        end else if (at_limit) begin
          state_d     = S_DONE;
          req_valid_d = 1'b0;
          done_d      = 1'b1;
          err_d       = 1'b1;
          code_d      = E_TIMEOUT;
          rdata_d     = '0;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (mem_rsp_valid) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          if (mem_rsp_err) begin
            err_d   = 1'b1;
            code_d  = E_BUS;
            rdata_d = '0;
          end else begin
            err_d   = 1'b0;
            rdata_d = req_write_q ? '0 : load_val;
          end
        end else if (at_limit) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
          code_d  = E_TIMEOUT;
          rdata_d = '0;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      f3_q        <= '0;
      lane_q      <= '0;
      req_valid_q <= 1'b0;
      req_write_q <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_be_q    <= '0;
      done_q      <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      code_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      f3_q        <= f3_d;
      lane_q      <= lane_d;
      req_valid_q <= req_valid_d;
      req_write_q <= req_write_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_be_q    <= req_be_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      code_q      <= code_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: transaction-level reference model driving a
// randomized memory, with a per-cycle compare process and directed cases.
module tb_load_store_unit;

  localparam int unsigned TO = 16;

  logic        clk, reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [2:0]  cmd_func3;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        mem_req_valid, mem_req_ready, mem_req_write;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_be;
  logic        mem_rsp_valid, mem_rsp_err;
  logic [31:0] mem_rsp_rdata;
  logic        done, err;
  logic [31:0] rdata;
  logic [1:0]  err_code;

  load_store_unit #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_func3(cmd_func3), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_be(mem_req_be),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .mem_rsp_err(mem_rsp_err),
    .done(done), .rdata(rdata), .err(err), .err_code(err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Model expectations for the current cycle
  bit          chk_en = 1'b0;
  logic        exp_ready, exp_req_valid, exp_req_write, exp_done, exp_err;
  logic [31:0] exp_req_addr, exp_req_wdata, exp_rdata;
  logic [3:0]  exp_be;
  logic [1:0]  exp_code;
  bit          exp_fields_zero, exp_rdata_known;

  // Per-cycle compare of DUT against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmd_ready", cmd_ready, exp_ready);
      chk("mem_req_valid", mem_req_valid, exp_req_valid);
      if (exp_req_valid || exp_fields_zero) begin
        chk("mem_req_write", mem_req_write, exp_req_write);
        chk("mem_req_addr", mem_req_addr, exp_req_addr);
        chk("mem_req_wdata", mem_req_wdata, exp_req_wdata);
        chk("mem_req_be", mem_req_be, exp_be);
      end
      chk("done", done, exp_done);
      chk("err", err, exp_err);
      if (exp_err) chk("err_code", err_code, exp_code);
      if (exp_rdata_known) chk("rdata", rdata, exp_rdata);
    end
  end

  // Observation helpers for the directed cases
  int          cyc = 0;
  int          acc_cyc = 0;
  int          last_done_cyc = 0;
  int          done_cnt = 0;
  bit          req_seen = 1'b0;
  logic [3:0]  last_be;
  logic [31:0] last_addr, last_wdata;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done === 1'b1) begin
      last_done_cyc = cyc;
      done_cnt++;
    end
    if (mem_req_valid === 1'b1) begin
      req_seen   = 1'b1;
      last_be    = mem_req_be;
      last_addr  = mem_req_addr;
      last_wdata = mem_req_wdata;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit legal(input bit w, input logic [2:0] f);
    if (w) return (f == 3'd0 || f == 3'd1 || f == 3'd2);
    return (f == 3'd0 || f == 3'd1 || f == 3'd2 || f == 3'd4 || f == 3'd5);
  endfunction

  function automatic int nbytes(input logic [2:0] f);
    case (f)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  task automatic mem_quiet();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_err   = 1'b0;
    mem_rsp_rdata = '0;
  endtask

  // Idle cycles with random stray memory activity, which must be ignored
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cmd_valid     = 1'b0;
      mem_req_ready = 1'($urandom);
      mem_rsp_valid = 1'($urandom);
      mem_rsp_err   = 1'($urandom);
      mem_rsp_rdata = $urandom;
      step();
    end
    mem_quiet();
  endtask

  // One command: rdly = cycles of ready low in REQ, wdly = WAIT cycles
  // before the response, rst_at = REQ/WAIT cycle index carrying reset (-1 none)
  task automatic run_txn(input bit w, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int rdly, input int wdly,
                         input bit rerr, input logic [31:0] word, input int rst_at);
    int nb, lane, k, wn;
    bit in_wait;
    logic [31:0] sh, ld;
    nb   = nbytes(f3);
    lane = int'(addr[1:0]);
    cmd_valid = 1'b1; cmd_write = w; cmd_func3 = f3; cmd_addr = addr; cmd_wdata = wd;
    step();
    acc_cyc = cyc;
    cmd_valid = 1'($urandom); cmd_write = 1'($urandom); cmd_func3 = 3'($urandom);
    cmd_addr = $urandom; cmd_wdata = $urandom;
    exp_ready = 1'b0;
    exp_fields_zero = 1'b0;
    if (!legal(w, f3) || (addr % nb) != 0) begin
      exp_done = 1'b1; exp_err = 1'b1; exp_code = legal(w, f3) ? 2'd0 : 2'd1;
      exp_rdata_known = 1'b0; exp_req_valid = 1'b0;
      cmd_valid = 1'b0;
      step();
      exp_done = 1'b0; exp_ready = 1'b1;
      return;
    end
    exp_req_valid = 1'b1;
    exp_req_write = w;
    exp_req_addr  = addr & ~32'd3;
    exp_be        = 4'(((1 << nb) - 1) << lane);
    if (!w)          exp_req_wdata = '0;
    else if (nb == 1) exp_req_wdata = wd[7:0] * 32'h01010101;
    else if (nb == 2) exp_req_wdata = wd[15:0] * 32'h00010001;
    else             exp_req_wdata = wd;
    in_wait = 1'b0; wn = 0; k = 0;
    while (1) begin
      k++;
      if (!in_wait) begin
        mem_req_ready = (k > rdly);
        mem_rsp_valid = 1'($urandom);
        mem_rsp_err   = 1'($urandom);
        mem_rsp_rdata = $urandom;
      end else begin
        mem_req_ready = 1'($urandom);
        mem_rsp_valid = (wn >= wdly);
        mem_rsp_err   = rerr;
        mem_rsp_rdata = mem_rsp_valid ? word : $urandom;
      end
      if (k == rst_at) reset = 1'b1;
      step();
      if (reset) begin
        reset = 1'b0;
        cmd_valid = 1'b0;
        mem_quiet();
        exp_ready = 1'b1; exp_req_valid = 1'b0; exp_fields_zero = 1'b1;
        exp_req_write = 1'b0; exp_req_addr = '0; exp_req_wdata = '0; exp_be = '0;
        exp_done = 1'b0; exp_err = 1'b0; exp_code = '0;
        exp_rdata = '0; exp_rdata_known = 1'b1;
        return;
      end
      if (!in_wait && mem_req_ready) begin
        in_wait = 1'b1;
        exp_req_valid = 1'b0;
      end else if (in_wait && mem_rsp_valid) begin
        exp_done = 1'b1;
        exp_rdata_known = 1'b1;
        if (rerr) begin
          exp_err = 1'b1; exp_code = 2'd2; exp_rdata = '0;
        end else if (w) begin
          exp_err = 1'b0; exp_rdata = '0;
        end else begin
          exp_err = 1'b0;
          sh = word >> (8 * lane);
          if (nb == 1) begin
            ld = sh & 32'hFF;
            if (!f3[2] && sh[7]) ld = ld | 32'hFFFFFF00;
          end else if (nb == 2) begin
            ld = sh & 32'hFFFF;
            if (!f3[2] && sh[15]) ld = ld | 32'hFFFF0000;
          end else begin
            ld = word;
          end
          exp_rdata = ld;
        end
        break;
      end else if (k >= TO) begin
        exp_req_valid = 1'b0;
        exp_done = 1'b1; exp_err = 1'b1; exp_code = 2'd3;
        exp_rdata_known = 1'b0;
        break;
      end else if (in_wait) begin
        wn++;
      end
    end
    cmd_valid = 1'b0;
    mem_quiet();
    step();
    exp_done = 1'b0;
    exp_ready = 1'b1;
  endtask

  initial begin
    int n0;
    bit w;
    logic [2:0] f3;
    logic [31:0] a;
    int rd, wdl, ra;
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_func3 = '0; cmd_addr = '0; cmd_wdata = '0;
    mem_quiet();
    step();
    step();
    reset = 1'b0;
    exp_ready = 1'b1; exp_req_valid = 1'b0; exp_fields_zero = 1'b1;
    exp_req_write = 1'b0; exp_req_addr = '0; exp_req_wdata = '0; exp_be = '0;
    exp_done = 1'b0; exp_err = 1'b0; exp_code = '0; exp_rdata = '0; exp_rdata_known = 1'b1;
    chk_en = 1'b1;
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_rdata", rdata, 0);

    // LB with sign extension
    run_txn(1'b0, 3'b000, 32'h103, 32'h0, 0, 0, 1'b0, 32'h80112233, -1);
    chk("lb_rdata", rdata, 32'hFFFFFF80);
    chk("lb_be", last_be, 4'b1000);
    chk("lb_addr", last_addr, 32'h100);
    chk("lb_err", err, 0);
    chk("lb_latency", last_done_cyc - acc_cyc + 1, 3);
    idle(1);

    // SH upper half with two stall cycles
    run_txn(1'b1, 3'b001, 32'h202, 32'h0000ABCD, 2, 0, 1'b0, 32'h0, -1);
    chk("sh_be", last_be, 4'b1100);
    chk("sh_wdata", last_wdata, 32'hABCDABCD);
    chk("sh_addr", last_addr, 32'h200);
    chk("sh_rdata", rdata, 0);
    chk("sh_latency", last_done_cyc - acc_cyc + 1, 5);
    idle(1);

    // Faults without a bus request
    req_seen = 1'b0;
    run_txn(1'b0, 3'b010, 32'h101, 32'h0, 0, 0, 1'b0, 32'h0, -1);
    chk("lw_mis_err", err, 1);
    chk("lw_mis_code", err_code, 0);
    chk("lw_mis_latency", last_done_cyc - acc_cyc + 1, 1);
    chk("lw_mis_noreq", req_seen, 0);
    run_txn(1'b1, 3'b100, 32'h40, 32'h55, 0, 0, 1'b0, 32'h0, -1);
    chk("st_ill_err", err, 1);
    chk("st_ill_code", err_code, 1);
    chk("st_ill_latency", last_done_cyc - acc_cyc + 1, 1);
    chk("st_ill_noreq", req_seen, 0);

    // Timeout, then a late response that must be ignored
    run_txn(1'b0, 3'b010, 32'h0, 32'h0, 0, 100, 1'b0, 32'h0, -1);
    chk("to_err", err, 1);
    chk("to_code", err_code, 3);
    chk("to_latency", last_done_cyc - acc_cyc + 1, TO + 1);
    n0 = done_cnt;
    mem_quiet();
    step();
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hCAFEF00D;
    step();
    mem_quiet();
    step();
    step();
    chk("to_late_rsp_nodone", done_cnt - n0, 0);

    // Bus error, then zero-extended halfword
    run_txn(1'b0, 3'b101, 32'h2, 32'h0, 0, 1, 1'b1, 32'hDEADBEEF, -1);
    chk("buserr_code", err_code, 2);
    chk("buserr_rdata", rdata, 0);
    run_txn(1'b0, 3'b101, 32'h2, 32'h0, 1, 0, 1'b0, 32'hF00D1234, -1);
    chk("lhu_rdata", rdata, 32'h0000F00D);
    chk("lhu_err", err, 0);

    // Reset during WAIT
    n0 = done_cnt;
    run_txn(1'b0, 3'b010, 32'h10, 32'h0, 0, 5, 1'b0, 32'h12345678, 3);
    chk("rstw_req_valid", mem_req_valid, 0);
    chk("rstw_done", done, 0);
    chk("rstw_rdata", rdata, 0);
    chk("rstw_err", err, 0);
    chk("rstw_code", err_code, 0);
    chk("rstw_be", mem_req_be, 0);
    idle(2);
    chk("rstw_nodone", done_cnt - n0, 0);
    run_txn(1'b0, 3'b010, 32'h20, 32'h0, 0, 0, 1'b0, 32'h12345678, -1);
    chk("after_rst_rdata", rdata, 32'h12345678);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      w   = 1'($urandom);
      f3  = 3'($urandom);
      a   = $urandom;
      if ($urandom % 2 == 0) a[1:0] = 2'b00;
      rd  = int'($urandom % 4);
      wdl = int'($urandom % 4);
      if ($urandom % 20 == 0) wdl = 40;
      if ($urandom % 20 == 0) rd = 40;
      ra  = ($urandom % 16 == 0) ? int'($urandom_range(1, 5)) : -1;
      run_txn(w, f3, a, $urandom, rd, wdl, ($urandom % 8 == 0), $urandom, ra);
      idle(int'($urandom % 3));
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the core's data-memory interface. It accepts one load or store command per transaction from the execute stage and issues a word-aligned, byte-enabled request on a valid/ready memory bus. It waits for the memory response, then lane-extracts and sign/zero-extends load data. It reports completion, or a misalignment, illegal-width, bus-error or timeout fault, through a one-cycle `done` pulse.

## Interface
Parameters:
- `TIMEOUT_CYC`, 16: maximum cycles spent in REQ+WAIT before a timeout fault (≥2).

Ports:
- `clk` in 1: sole clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high; one clock; reset is synchronous and active-high.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: `(state==IDLE) && !reset`.
- `cmd_write` in 1: 1 = store, 0 = load.
- `cmd_func3` in 3: 000 B, 001 H, 010 W, 100 BU (load only), 101 HU (load only).
- `cmd_addr` in 32: byte address.
- `cmd_wdata` in 32: store data, right-aligned.
- `mem_req_valid` out 1: request valid.
- `mem_req_ready` in 1: memory accepts the request.
- `mem_req_write` out 1: request is a write.
- `mem_req_addr` out 32: `{addr[31:2],2'b00}`.
- `mem_req_wdata` out 32: lane-replicated store data.
- `mem_req_be` out 4: byte enables.
- `mem_rsp_valid` in 1: response or write-ack valid.
- `mem_rsp_rdata` in 32: read word.
- `mem_rsp_err` in 1: bus error, qualified by `mem_rsp_valid`.
- `done` out 1: one-cycle completion pulse.
- `rdata` out 32: formatted load data; valid while `done`.
- `err` out 1: fault flag; valid while `done`.
- `err_code` out 2: 0 misaligned, 1 illegal func3, 2 bus error, 3 timeout.

## Operation
- States: IDLE, REQ, WAIT, DONE. Reset forces IDLE.
- Registered outputs reset to 0: `mem_req_*`, `done`, `rdata`, `err`, `err_code`.
- **IDLE, on handshake** (`cmd_valid && cmd_ready`): capture all `cmd_*` fields and compute `lane = addr[1:0]`.
  - Illegal func3: store with func3 not in {000,001,010}, or load with func3 not in {000,001,010,100,101}. Go to DONE with `err=1`, code 1. No bus request is issued.
  - Misaligned: H/HU with `lane[0]=1`, or W with `lane≠0`. Go to DONE with `err=1`, code 0. No bus request is issued.
  - Otherwise go to REQ and clear the timeout counter.
- **Byte enables:**
  - B/BU: `be = 4'b0001 << lane`.
  - H/HU: `be = 4'b0011 << lane`.
  - W: `be = 4'b1111`.
- **Store data:**
  - SB: `wdata = {4{cmd_wdata[7:0]}}`.
  - SH: `wdata = {2{cmd_wdata[15:0]}}`.
  - SW: `wdata = cmd_wdata`.
  - Loads drive `wdata = 0`.
- **REQ:** hold `mem_req_valid=1` with all `mem_req_*` fields stable until `mem_req_ready`, then go to WAIT. `mem_req_valid` must never drop without a handshake, except on reset or timeout.
- **WAIT:** on `mem_rsp_valid`:
  - If `mem_rsp_err`: go to DONE with `err=1`, code 2, `rdata=0`.
  - Else for a load: `sh = mem_rsp_rdata >> (8*lane)`; B → `{{24{sh[7]}},sh[7:0]}`, BU → zero-extend byte, H → `{{16{sh[15]}},sh[15:0]}`, HU → zero-extend half, W → word. Go to DONE with `err=0`.
  - Else for a store: `rdata=0`, `err=0`, go to DONE.
- **Timeout:** the counter increments every cycle in REQ and WAIT. When it reaches `TIMEOUT_CYC` and no handshake or response occurs in that cycle, go to DONE with `err=1`, code 3, and drop `mem_req_valid`.
- **DONE:** `done=1` for exactly one cycle, then IDLE. `rdata`, `err`, `err_code` hold until the next `done`.
- **Stray responses:** `mem_rsp_valid` outside WAIT, including a late response after a timeout, is ignored. If a response and the timeout coincide in WAIT, the response wins.
- **Reset mid-transaction:** abandon at the next edge. Return to IDLE, drop `mem_req_valid`, and issue no `done`.

## Timing
- Command accepted at edge T:
  - Fault-free with `mem_req_ready=1` in REQ and response in the first WAIT cycle: REQ during T..T+1, WAIT during T+1..T+2, `done` high during T+3.
  - Latency is therefore 3 cycles plus memory stall cycles.
- Misaligned or illegal command: `done` high in the cycle immediately after acceptance (1 cycle).
- `cmd_ready` is low from the acceptance cycle until back in IDLE. Back-to-back commands are separated by at least one IDLE cycle.

## Test plan
- **LB with sign extension:** `addr=0x103`, memory returns `0x80_11_22_33` → `be=1000`, `mem_req_addr=0x100`, `rdata=0xFFFFFF80`, `err=0`, `done` 3 cycles after acceptance.
- **SH, upper half:** `addr=0x202`, `cmd_wdata=0x0000ABCD`, `mem_req_ready` low for 2 cycles → `mem_req_*` stable throughout, `be=1100`, `wdata=0xABCDABCD`, `done` on ack with `rdata=0`.
- **Faults without a bus request:** LW at `0x101` → `err=1`, code 0. Store with func3=100 → `err=1`, code 1. Both: `done` next cycle, `mem_req_valid` never asserted.
- **Timeout:** `TIMEOUT_CYC=16`, memory never responds → `done` with code 3. A response injected 2 cycles later is ignored and produces no second `done`.
- **Bus error and zero-extension:** LHU at `0x2` returns `mem_rsp_err=1` → code 2. A following LHU at `0x2` with `rdata=0xF00D1234` → `rdata=0x0000F00D`.
- **Reset in WAIT:** assert `reset` for 1 cycle during WAIT → IDLE next cycle, no `done`, all outputs 0. The next command completes normally.
